// File: rtl/mmu_resp_router_pkg.sv
// Shared constants for the MMU response router: owner encoding, fault FSM states,
// and tag-queue entry sizing.
package mmu_resp_router_pkg;

  localparam int unsigned OWNER_W = 3;

  localparam logic [OWNER_W-1:0] OWNER_WALK    = 3'd0;
  localparam logic [OWNER_W-1:0] OWNER_CH_BASE = 3'd1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // Tag entry is {owner, flags}
  function automatic int unsigned entry_w(input int unsigned flag_w);
    return OWNER_W + flag_w;
  endfunction

endpackage

// File: rtl/mmu_resp_router_if.sv
// MMU/memory/channel signal bundle for mmu_resp_router.
// The slave modport is the router's view; master is the surrounding system.
interface mmu_resp_router_if
  import mmu_resp_router_pkg::*;
#(
  parameter int unsigned P_CH     = 2,
  parameter int unsigned P_DATA_W = 64,
  parameter int unsigned P_FLAG_W = 28
);

  logic                   iMMU_REQ;
  logic                   iMMU_STORE;
  logic [OWNER_W-1:0]     iMMU_OWNER;
  logic [P_FLAG_W-1:0]    iMMU_FLAGS;
  logic                   oMMU_LOCK;
  logic                   iFAULT_VALID;
  logic [OWNER_W-1:0]     iFAULT_CH;
  logic                   oMEM_REQ;
  logic                   iMEM_LOCK;
  logic                   iMEM_VALID;
  logic [P_DATA_W-1:0]    iMEM_DATA;
  logic                   oMEM_LOCK;
  logic                   oWALK_VALID;
  logic [P_DATA_W-1:0]    oWALK_DATA;
  logic                   iWALK_LOCK;
  logic [P_CH-1:0]        oCH_VALID;
  logic [P_CH*P_DATA_W-1:0] oCH_DATA;
  logic [P_CH*P_FLAG_W-1:0] oCH_FLAGS;
  logic [P_CH-1:0]        oCH_STORE_ACK;
  logic [P_CH-1:0]        oCH_FAULT;
  logic [P_CH-1:0]        iCH_LOCK;
  logic                   oERR_UNEXP;

  modport slave (
    input  iMMU_REQ, iMMU_STORE, iMMU_OWNER, iMMU_FLAGS, iFAULT_VALID, iFAULT_CH,
    input  iMEM_LOCK, iMEM_VALID, iMEM_DATA, iWALK_LOCK, iCH_LOCK,
    output oMMU_LOCK, oMEM_REQ, oMEM_LOCK, oWALK_VALID, oWALK_DATA,
    output oCH_VALID, oCH_DATA, oCH_FLAGS, oCH_STORE_ACK, oCH_FAULT, oERR_UNEXP
  );

  modport master (
    output iMMU_REQ, iMMU_STORE, iMMU_OWNER, iMMU_FLAGS, iFAULT_VALID, iFAULT_CH,
    output iMEM_LOCK, iMEM_VALID, iMEM_DATA, iWALK_LOCK, iCH_LOCK,
    input  oMMU_LOCK, oMEM_REQ, oMEM_LOCK, oWALK_VALID, oWALK_DATA,
    input  oCH_VALID, oCH_DATA, oCH_FLAGS, oCH_STORE_ACK, oCH_FAULT, oERR_UNEXP
  );

endinterface

// File: rtl/mmu_tag_fifo.sv
// In-order tag queue with show-ahead head; full/empty/count reflect pre-edge occupancy.
module mmu_tag_fifo #(
  parameter int unsigned P_WIDTH   = 31,
  parameter int unsigned P_DEPTH   = 16,
  parameter int unsigned P_DEPTH_N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [P_WIDTH-1:0]   din,
  input  logic                 pop,
  output logic [P_WIDTH-1:0]   dout,
  output logic                 full,
  output logic                 empty,
  output logic [P_DEPTH_N:0]   count
);

  localparam int unsigned PTR_W = P_DEPTH_N;
  localparam int unsigned CNT_W = P_DEPTH_N + 1;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               do_push, do_pop;

  assign full    = (cnt == CNT_W'(P_DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin : ptr_reg
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin : mem_write
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmu_resp_router.sv
// Routes in-order memory read responses to the walker or a core channel, returns
// store acks, and sequences the per-channel page-fault drain and report.
module mmu_resp_router
  import mmu_resp_router_pkg::*;
#(
  parameter int unsigned P_CH      = 2,
  parameter int unsigned P_DATA_W  = 64,
  parameter int unsigned P_FLAG_W  = 28,
  parameter int unsigned P_DEPTH   = 16,
  parameter int unsigned P_DEPTH_N = 4
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  mmu_resp_router_if.slave   bus
);

  localparam int unsigned ENTRY_W = entry_w(P_FLAG_W);
  localparam int unsigned CNT_W   = P_DEPTH_N + 1;

  logic [1:0]               state, state_n;
  logic [OWNER_W-1:0]       fc, fc_n;
  logic [P_CH-1:0]          ch_valid, ch_fault, store_ack;
  logic [P_CH*P_DATA_W-1:0] ch_data;
  logic [P_CH*P_FLAG_W-1:0] ch_flags;
  logic                     err_unexp;

  logic                     q_full, q_empty;
  logic [CNT_W-1:0]         q_count;
  logic [ENTRY_W-1:0]       q_head;
  logic [OWNER_W-1:0]       head_owner;
  logic [P_FLAG_W-1:0]      head_flags;

  logic [P_CH-1:0]          head_mask, store_mask, fc_mask, load;
  logic                     head_walk, head_blocked, mmu_lock, mem_lock;
  logic                     acc, push, take, report_load;

  assign {head_owner, head_flags} = q_head;

  always_comb begin : owner_decode
    head_mask  = '0;
    store_mask = '0;
    fc_mask    = '0;
    for (int c = 0; c < P_CH; c++) begin
      head_mask[c]  = (head_owner == OWNER_CH_BASE + OWNER_W'(c));
      store_mask[c] = (bus.iMMU_OWNER == OWNER_CH_BASE + OWNER_W'(c));
      fc_mask[c]    = (fc == OWNER_W'(c));
    end
  end

  // Full is the pre-pop view, so a same-cycle response never unlocks a full queue
  assign head_walk    = (head_owner == OWNER_WALK);
  assign head_blocked = |(head_mask & ch_valid & bus.iCH_LOCK);
  assign mem_lock     = q_empty || (head_walk && bus.iWALK_LOCK) || head_blocked;
  assign take         = bus.iMEM_VALID && !mem_lock;
  assign mmu_lock     = bus.iMEM_LOCK || (q_full && !bus.iMMU_STORE) ||
                        bus.iFAULT_VALID || (state != ST_IDLE);
  assign acc          = bus.iMMU_REQ && !mmu_lock;
  assign push         = acc && !bus.iMMU_STORE;
  assign load         = take ? head_mask : '0;

  mmu_tag_fifo #(
    .P_WIDTH   (ENTRY_W),
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_N (P_DEPTH_N)
  ) u_tag_fifo (
    .clk   (iCLOCK),
    .rst   (iRESET_SYNC),
    .push  (push),
    .din   ({bus.iMMU_OWNER, bus.iMMU_FLAGS}),
    .pop   (take),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin : fsm_next
    state_n     = state;
    fc_n        = fc;
    report_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.iFAULT_VALID) begin
          state_n = ST_DRAIN;
          fc_n    = (bus.iFAULT_CH >= OWNER_W'(P_CH)) ? OWNER_W'(0) : bus.iFAULT_CH;
        end
      end
      ST_DRAIN: begin
        if ((q_count == '0) && !(|(fc_mask & ch_valid))) begin
          state_n     = ST_REPORT;
          report_load = 1'b1;
        end
      end
      ST_REPORT: begin
        if (!(|(fc_mask & bus.iCH_LOCK))) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin : fsm_reg
    if (iRESET_SYNC) begin
      state <= ST_IDLE;
      fc    <= '0;
    end else begin
      state <= state_n;
      fc    <= fc_n;
    end
  end

  // Per-channel output latch; the fault report reuses it with zeroed payload
  always_ff @(posedge iCLOCK) begin : ch_latch
    if (iRESET_SYNC) begin
      ch_valid  <= '0;
      ch_fault  <= '0;
      ch_data   <= '0;
      ch_flags  <= '0;
      store_ack <= '0;
      err_unexp <= 1'b0;
    end else begin
      for (int c = 0; c < P_CH; c++) begin
        if (load[c]) begin
          ch_valid[c]                       <= 1'b1;
          ch_fault[c]                       <= 1'b0;
          ch_data[c*P_DATA_W +: P_DATA_W]   <= bus.iMEM_DATA;
          ch_flags[c*P_FLAG_W +: P_FLAG_W]  <= head_flags;
        end else if (report_load && fc_mask[c]) begin
          ch_valid[c]                       <= 1'b1;
          ch_fault[c]                       <= 1'b1;
          ch_data[c*P_DATA_W +: P_DATA_W]   <= '0;
          ch_flags[c*P_FLAG_W +: P_FLAG_W]  <= '0;
        end else if (ch_valid[c] && !bus.iCH_LOCK[c]) begin
          ch_valid[c] <= 1'b0;
          ch_fault[c] <= 1'b0;
        end
      end
      store_ack <= (acc && bus.iMMU_STORE) ? store_mask : '0;
      if (bus.iMEM_VALID && q_empty) err_unexp <= 1'b1;
    end
  end

  assign bus.oMMU_LOCK     = mmu_lock;
  assign bus.oMEM_REQ      = acc;
  assign bus.oMEM_LOCK     = mem_lock;
  assign bus.oWALK_VALID   = bus.iMEM_VALID && head_walk && !q_empty && !bus.iWALK_LOCK;
  assign bus.oWALK_DATA    = bus.iMEM_DATA;
  assign bus.oCH_VALID     = ch_valid;
  assign bus.oCH_DATA      = ch_data;
  assign bus.oCH_FLAGS     = ch_flags;
  assign bus.oCH_STORE_ACK = store_ack;
  assign bus.oCH_FAULT     = ch_fault;
  assign bus.oERR_UNEXP    = err_unexp;

endmodule

// File: tb/tb_mmu_resp_router.sv
// Scoreboard bench for mmu_resp_router: a model tag queue predicts the owner of
// each response; per-owner expected queues are compared when outputs are consumed.
module tb_mmu_resp_router;

  localparam int unsigned CH      = 2;
  localparam int unsigned DW      = 64;
  localparam int unsigned FW      = 28;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DEPTH_N = 4;

  typedef struct packed {
    logic [2:0]    owner;
    logic [FW-1:0] flags;
  } tag_t;

  typedef struct packed {
    logic          fault;
    logic [DW-1:0] data;
    logic [FW-1:0] flags;
  } ch_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmu_resp_router_if #(.P_CH(CH), .P_DATA_W(DW), .P_FLAG_W(FW)) bus();

  mmu_resp_router #(
    .P_CH(CH), .P_DATA_W(DW), .P_FLAG_W(FW), .P_DEPTH(DEPTH), .P_DEPTH_N(DEPTH_N)
  ) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .bus         (bus)
  );

  tag_t          tag_q [$];
  ch_exp_t       ch_q  [CH][$];
  logic [DW-1:0] walk_q[$];
  int            errors = 0;
  int            checks = 0;

  logic [DW-1:0] mon_w;
  ch_exp_t       mon_e;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Consumption monitor: walker beats and channel latches taken downstream
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oWALK_VALID) begin
        check("walk_q_nonempty", 64'(walk_q.size() != 0), 64'd1);
        if (walk_q.size() != 0) begin
          mon_w = walk_q.pop_front();
          check("walk_data", bus.oWALK_DATA, mon_w);
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (bus.oCH_VALID[c] && !bus.iCH_LOCK[c]) begin
          check("ch_q_nonempty", 64'(ch_q[c].size() != 0), 64'd1);
          if (ch_q[c].size() != 0) begin
            mon_e = ch_q[c].pop_front();
            check("ch_fault", 64'(bus.oCH_FAULT[c]), 64'(mon_e.fault));
            check("ch_data", bus.oCH_DATA[c*DW +: DW], mon_e.data);
            check("ch_flags", 64'(bus.oCH_FLAGS[c*FW +: FW]), 64'(mon_e.flags));
          end
        end
      end
    end
  end

  task automatic read(input logic [2:0] owner, input logic [FW-1:0] flags);
    tag_t t;
    bus.iMMU_REQ   = 1'b1;
    bus.iMMU_STORE = 1'b0;
    bus.iMMU_OWNER = owner;
    bus.iMMU_FLAGS = flags;
    #2;
    check("read_mmu_lock", 64'(bus.oMMU_LOCK), 64'd0);
    check("read_mem_req", 64'(bus.oMEM_REQ), 64'd1);
    t.owner = owner;
    t.flags = flags;
    tag_q.push_back(t);
    tick;
    bus.iMMU_REQ = 1'b0;
  endtask

  task automatic resp(input logic [DW-1:0] data, input bit full_chk);
    tag_t    t;
    ch_exp_t e;
    int      c;
    c = 0;
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = data;
    #2;
    check("resp_mem_lock", 64'(bus.oMEM_LOCK), 64'd0);
    if (full_chk) check("full_pop_mmu_lock", 64'(bus.oMMU_LOCK), 64'd1);
    t = tag_q.pop_front();
    if (t.owner == 3'd0) begin
      check("walk_valid", 64'(bus.oWALK_VALID), 64'd1);
      walk_q.push_back(data);
    end else begin
      c = int'(t.owner) - 1;
      e.fault = 1'b0;
      e.data  = data;
      e.flags = t.flags;
      ch_q[c].push_back(e);
      check("walk_idle", 64'(bus.oWALK_VALID), 64'd0);
    end
    tick;
    bus.iMEM_VALID = 1'b0;
    if (t.owner != 3'd0) begin
      check("ch_valid_next", 64'(bus.oCH_VALID[c]), 64'd1);
      check("ch_data_next", bus.oCH_DATA[c*DW +: DW], data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ch_exp_t e;
    bit      seen;
    bus.iMMU_REQ = 0; bus.iMMU_STORE = 0; bus.iMMU_OWNER = '0; bus.iMMU_FLAGS = '0;
    bus.iFAULT_VALID = 0; bus.iFAULT_CH = '0; bus.iMEM_LOCK = 0; bus.iMEM_VALID = 0;
    bus.iMEM_DATA = '0; bus.iWALK_LOCK = 0; bus.iCH_LOCK = '0;

    repeat (3) tick;
    rst = 1'b0;
    check("rst_ch_valid", 64'(bus.oCH_VALID), 64'd0);
    check("rst_store_ack", 64'(bus.oCH_STORE_ACK), 64'd0);
    check("rst_err", 64'(bus.oERR_UNEXP), 64'd0);
    check("rst_mmu_lock", 64'(bus.oMMU_LOCK), 64'd0);
    check("rst_walk_valid", 64'(bus.oWALK_VALID), 64'd0);

    // Memory back-pressure blocks acceptance
    bus.iMEM_LOCK = 1'b1; bus.iMMU_REQ = 1'b1; bus.iMMU_OWNER = 3'd1;
    #1;
    check("memlock_mmu_lock", 64'(bus.oMMU_LOCK), 64'd1);
    check("memlock_mem_req", 64'(bus.oMEM_REQ), 64'd0);
    bus.iMEM_LOCK = 1'b0; bus.iMMU_REQ = 1'b0;

    // Single channel-0 read
    read(3'd1, 28'h0ABCDEF);
    resp(64'h1122334455667788, 1'b0);
    check("t1_flags", 64'(bus.oCH_FLAGS[0 +: FW]), 64'h0ABCDEF);
    check("t1_fault", 64'(bus.oCH_FAULT[0]), 64'd0);
    tick;

    // Interleaved owners walker, ch1, ch0
    read(3'd0, 28'h0000001);
    read(3'd2, 28'h0000222);
    read(3'd1, 28'h0000111);
    resp(64'h0000_0000_0000_AAAA, 1'b0);
    resp(64'h0000_0000_0000_BBBB, 1'b0);
    resp(64'h0000_0000_0000_CCCC, 1'b0);
    tick;

    // Fill the queue, then full lock, store bypass, walker store
    for (int i = 0; i < 16; i++) read(3'd1, 28'(i));
    bus.iMMU_REQ = 1'b1; bus.iMMU_STORE = 1'b0; bus.iMMU_OWNER = 3'd1;
    #1;
    check("full_mmu_lock", 64'(bus.oMMU_LOCK), 64'd1);
    check("full_mem_req", 64'(bus.oMEM_REQ), 64'd0);
    bus.iMMU_STORE = 1'b1; bus.iMMU_OWNER = 3'd2;
    #1;
    check("store_full_lock", 64'(bus.oMMU_LOCK), 64'd0);
    check("store_full_req", 64'(bus.oMEM_REQ), 64'd1);
    tick;
    bus.iMMU_REQ = 1'b0; bus.iMMU_STORE = 1'b0;
    check("store_ack_ch1", 64'(bus.oCH_STORE_ACK), 64'd2);
    bus.iMMU_REQ = 1'b1; bus.iMMU_STORE = 1'b1; bus.iMMU_OWNER = 3'd0;
    #1;
    check("store_walk_lock", 64'(bus.oMMU_LOCK), 64'd0);
    tick;
    bus.iMMU_REQ = 1'b0; bus.iMMU_STORE = 1'b0;
    check("store_walk_no_ack", 64'(bus.oCH_STORE_ACK), 64'd0);
    bus.iMMU_REQ = 1'b1; bus.iMMU_OWNER = 3'd1;
    resp({32'hA5A5_0000, 32'd0}, 1'b1);
    bus.iMMU_REQ = 1'b0;
    for (int i = 1; i < 16; i++) resp({32'hA5A5_0000, 32'(i)}, 1'b0);
    tick;

    // Channel back-pressure blocks the next response until released
    bus.iCH_LOCK = 2'b01;
    read(3'd1, 28'h44);
    read(3'd1, 28'h55);
    resp(64'h4444, 1'b0);
    bus.iMEM_VALID = 1'b1; bus.iMEM_DATA = 64'h5555;
    #2;
    check("blocked_mem_lock", 64'(bus.oMEM_LOCK), 64'd1);
    tick;
    #1;
    check("blocked_mem_lock2", 64'(bus.oMEM_LOCK), 64'd1);
    check("blocked_hold_data", bus.oCH_DATA[0 +: DW], 64'h4444);
    tick;
    bus.iCH_LOCK = 2'b00;
    #1;
    check("release_mem_lock", 64'(bus.oMEM_LOCK), 64'd0);
    e.fault = 1'b0; e.data = 64'h5555; e.flags = tag_q[0].flags;
    void'(tag_q.pop_front());
    ch_q[0].push_back(e);
    tick;
    bus.iMEM_VALID = 1'b0;
    check("reload_valid", 64'(bus.oCH_VALID[0]), 64'd1);
    check("reload_data", bus.oCH_DATA[0 +: DW], 64'h5555);
    tick;

    // Fault on channel 1 with two reads outstanding
    read(3'd1, 28'h61);
    read(3'd2, 28'h62);
    bus.iFAULT_VALID = 1'b1; bus.iFAULT_CH = 3'd1;
    #2;
    check("fault_mmu_lock", 64'(bus.oMMU_LOCK), 64'd1);
    tick;
    bus.iFAULT_CH = 3'd0;
    #2;
    check("drain_mmu_lock", 64'(bus.oMMU_LOCK), 64'd1);
    tick;
    bus.iFAULT_VALID = 1'b0;
    resp(64'h6161, 1'b0);
    resp(64'h6262, 1'b0);
    tick;
    bus.iCH_LOCK = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (bus.oCH_VALID[1]) seen = 1'b1;
      else tick;
    end
    check("report_seen", 64'(seen), 64'd1);
    e.fault = 1'b1; e.data = '0; e.flags = '0;
    ch_q[1].push_back(e);
    check("report_fault", 64'(bus.oCH_FAULT[1]), 64'd1);
    check("report_data", bus.oCH_DATA[DW +: DW], 64'd0);
    check("report_other_ch", 64'(bus.oCH_VALID[0]), 64'd0);
    check("report_mmu_lock", 64'(bus.oMMU_LOCK), 64'd1);
    repeat (3) begin
      tick;
      check("report_hold", 64'(bus.oCH_VALID[1]), 64'd1);
      check("report_hold_fault", 64'(bus.oCH_FAULT[1]), 64'd1);
    end
    bus.iCH_LOCK = 2'b00;
    tick;
    check("report_done_valid", 64'(bus.oCH_VALID), 64'd0);
    check("report_done_lock", 64'(bus.oMMU_LOCK), 64'd0);

    // Out-of-range fault channel reports on channel 0
    bus.iFAULT_VALID = 1'b1; bus.iFAULT_CH = 3'd5;
    tick;
    bus.iFAULT_VALID = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (bus.oCH_VALID[0]) seen = 1'b1;
      else tick;
    end
    check("oor_report_seen", 64'(seen), 64'd1);
    e.fault = 1'b1; e.data = '0; e.flags = '0;
    ch_q[0].push_back(e);
    check("oor_fault", 64'(bus.oCH_FAULT[0]), 64'd1);
    check("oor_other_ch", 64'(bus.oCH_VALID[1]), 64'd0);
    tick;
    check("oor_done_valid", 64'(bus.oCH_VALID), 64'd0);
    check("oor_done_lock", 64'(bus.oMMU_LOCK), 64'd0);

    // Unexpected response, sticky error, reset flush
    bus.iMEM_VALID = 1'b1; bus.iMEM_DATA = 64'hDEAD;
    #2;
    check("unexp_mem_lock", 64'(bus.oMEM_LOCK), 64'd1);
    check("unexp_walk", 64'(bus.oWALK_VALID), 64'd0);
    tick;
    bus.iMEM_VALID = 1'b0;
    check("unexp_err", 64'(bus.oERR_UNEXP), 64'd1);
    read(3'd2, 28'h77);
    repeat (3) tick;
    check("unexp_err_sticky", 64'(bus.oERR_UNEXP), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tag_q.delete();
    check("rst2_err", 64'(bus.oERR_UNEXP), 64'd0);
    check("rst2_ch_valid", 64'(bus.oCH_VALID), 64'd0);
    bus.iMEM_VALID = 1'b1;
    #1;
    check("rst2_flushed", 64'(bus.oMEM_LOCK), 64'd1);
    bus.iMEM_VALID = 1'b0;
    tick;

    check("sb_drained",
          64'(tag_q.size() + walk_q.size() + ch_q[0].size() + ch_q[1].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
